// File: rtl/pbch_re_demapper_if.sv
// Stream interface of the SS/PBCH RE demapper: FFT input beats and the data/DMRS/SSS output streams.
interface pbch_re_demapper_if #(
   parameter int SERIAL_WIDTH = 32
);
   logic [SERIAL_WIDTH-1:0] fft_data;
   logic                    fft_valid;
   logic                    fft_sof;
   logic                    ssb_start;
   logic [1:0]              cell_v;

   logic [SERIAL_WIDTH-1:0] data_out;
   logic                    data_valid;
   logic [8:0]              data_idx;
   logic                    data_grp_last;
   logic [SERIAL_WIDTH-1:0] dmrs_out;
   logic                    dmrs_valid;
   logic [7:0]              dmrs_idx;
   logic [SERIAL_WIDTH-1:0] sss_out;
   logic                    sss_valid;
   logic                    ssb_done;
   logic                    err;

   modport master (
      output fft_data, fft_valid, fft_sof, ssb_start, cell_v,
      input  data_out, data_valid, data_idx, data_grp_last,
             dmrs_out, dmrs_valid, dmrs_idx, sss_out, sss_valid, ssb_done, err
   );

   modport slave (
      input  fft_data, fft_valid, fft_sof, ssb_start, cell_v,
      output data_out, data_valid, data_idx, data_grp_last,
             dmrs_out, dmrs_valid, dmrs_idx, sss_out, sss_valid, ssb_done, err
   );
endinterface

// File: rtl/pbch_re_demapper.sv
// SS/PBCH post-FFT RE demapper: drops PSS, splits PBCH REs into DMRS and data streams.
// Define PBCH_DEMAP_SSS_EN to forward the SYM2 SSS REs on sss_out/sss_valid.
//
// state | meaning
// IDLE  | waiting for an ssb_start beat
// SYM0  | PSS symbol, every RE discarded
// SYM1  | full PBCH symbol
// SYM2  | PBCH edges, SSS centre, guards discarded
// SYM3  | full PBCH symbol, ends after k = 239
module pbch_re_demapper #(
   parameter int SERIAL_WIDTH = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   pbch_re_demapper_if.slave bus
);
   typedef enum logic [2:0] {IDLE, SYM0, SYM1, SYM2, SYM3} state_t;

   state_t                  state_q, state_d, sym_cur;
   logic [7:0]              k_q, k_d, k_cur;
   logic [1:0]              v_q, v_d;
   logic                    err_q, err_d;
   logic [8:0]              data_cnt_q, data_cnt_d;
   logic [1:0]              grp_q, grp_d;
   logic [7:0]              dmrs_cnt_q, dmrs_cnt_d;
   logic                    done_pend_q;
   logic                    beat, restart, in_sym, k_ok, short_sym, last_k;
   logic                    is_pbch, emit_data, emit_dmrs;
   logic [SERIAL_WIDTH-1:0] data_out_q, dmrs_out_q;
   logic                    data_valid_q, dmrs_valid_q, grp_last_q, ssb_done_q;
   logic [8:0]              data_idx_q;
   logic [7:0]              dmrs_idx_q;

   // k_q holds the index the next non-sof beat will carry
   assign beat      = bus.fft_valid;
   assign restart   = beat & bus.fft_sof & bus.ssb_start;
   assign in_sym    = (state_q != IDLE);
   assign k_cur     = bus.fft_sof ? 8'd0 : k_q;
   assign k_ok      = (k_cur < 8'd240);
   assign short_sym = beat & bus.fft_sof & (k_q < 8'd240) & (state_q inside {SYM1, SYM2, SYM3});
   assign last_k    = beat & ~bus.fft_sof & (state_q == SYM3) & (k_q == 8'd239);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (restart) begin
         state_d = SYM0;
      end else if (beat && in_sym) begin
         if (bus.fft_sof) begin
            case (state_q)
               SYM0:    state_d = SYM1;
               SYM1:    state_d = SYM2;
               SYM2:    state_d = SYM3;
               default: state_d = IDLE;
            endcase
         end else if (last_k) begin
            state_d = IDLE;
         end
      end
   end

   // a sof beat already belongs to the symbol being entered
   assign sym_cur = bus.fft_sof ? state_d : state_q;

   always_comb begin
      is_pbch   = (sym_cur == SYM1) || (sym_cur == SYM3) ||
                  ((sym_cur == SYM2) && ((k_cur < 8'd48) || (k_cur >= 8'd192)));
      emit_dmrs = beat & k_ok & is_pbch & (k_cur[1:0] == v_q);
      emit_data = beat & k_ok & is_pbch & (k_cur[1:0] != v_q);
   end

   always_comb begin
      k_d        = k_q;
      v_d        = v_q;
      err_d      = err_q;
      data_cnt_d = data_cnt_q;
      grp_d      = grp_q;
      dmrs_cnt_d = dmrs_cnt_q;
      if (beat) begin
         if (bus.fft_sof) k_d = 8'd1;
         else if (k_ok)   k_d = k_q + 8'd1;
      end
      if (restart) begin
         v_d        = bus.cell_v;
         err_d      = 1'b0;
         data_cnt_d = '0;
         grp_d      = '0;
         dmrs_cnt_d = '0;
      end else begin
         if ((beat && in_sym && !k_ok) || short_sym) err_d = 1'b1;
         if (emit_data) begin
            data_cnt_d = data_cnt_q + 9'd1;
            grp_d      = (grp_q == 2'd2) ? 2'd0 : grp_q + 2'd1;
         end
         if (emit_dmrs) dmrs_cnt_d = dmrs_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         k_q          <= '0;
         v_q          <= '0;
         err_q        <= 1'b0;
         data_cnt_q   <= '0;
         grp_q        <= '0;
         dmrs_cnt_q   <= '0;
         done_pend_q  <= 1'b0;
         ssb_done_q   <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         data_idx_q   <= '0;
         grp_last_q   <= 1'b0;
         dmrs_out_q   <= '0;
         dmrs_valid_q <= 1'b0;
         dmrs_idx_q   <= '0;
      end else begin
         k_q          <= k_d;
         v_q          <= v_d;
         err_q        <= err_d;
         data_cnt_q   <= data_cnt_d;
         grp_q        <= grp_d;
         dmrs_cnt_q   <= dmrs_cnt_d;
         done_pend_q  <= last_k;
         ssb_done_q   <= done_pend_q;
         data_valid_q <= emit_data;
         dmrs_valid_q <= emit_dmrs;
         grp_last_q   <= emit_data & (grp_q == 2'd2);
         if (emit_data) begin
            data_out_q <= bus.fft_data;
            data_idx_q <= data_cnt_q;
         end else if (restart) begin
            data_idx_q <= '0;
         end
         if (emit_dmrs) begin
            dmrs_out_q <= bus.fft_data;
            dmrs_idx_q <= dmrs_cnt_q;
         end else if (restart) begin
            dmrs_idx_q <= '0;
         end
      end
   end

`ifdef PBCH_DEMAP_SSS_EN
   logic                    is_sss, emit_sss, sss_valid_q;
   logic [SERIAL_WIDTH-1:0] sss_out_q;

   assign is_sss   = (sym_cur == SYM2) && (k_cur >= 8'd56) && (k_cur <= 8'd182);
   assign emit_sss = beat & k_ok & is_sss;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sss_out_q   <= '0;
         sss_valid_q <= 1'b0;
      end else begin
         sss_valid_q <= emit_sss;
         if (emit_sss) sss_out_q <= bus.fft_data;
      end
   end

   assign bus.sss_out   = sss_out_q;
   assign bus.sss_valid = sss_valid_q;
`else
   assign bus.sss_out   = '0;
   assign bus.sss_valid = 1'b0;
`endif

   assign bus.data_out      = data_out_q;
   assign bus.data_valid    = data_valid_q;
   assign bus.data_idx      = data_idx_q;
   assign bus.data_grp_last = grp_last_q;
   assign bus.dmrs_out      = dmrs_out_q;
   assign bus.dmrs_valid    = dmrs_valid_q;
   assign bus.dmrs_idx      = dmrs_idx_q;
   assign bus.ssb_done      = ssb_done_q;
   assign bus.err           = err_q;
endmodule

// File: tb/tb_pbch_re_demapper.sv
// Scoreboard bench for pbch_re_demapper: sample value = {symbol, k}, expected REs queued at drive time.
module tb_pbch_re_demapper;
   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   pbch_re_demapper_if #(.SERIAL_WIDTH(32)) bus ();
   pbch_re_demapper #(.SERIAL_WIDTH(32)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

   typedef struct {
      logic [31:0] val;
      int          idx;
      logic        last;
   } exp_t;

   exp_t q_data[$];
   exp_t q_dmrs[$];
   exp_t q_sss[$];
   int   checks = 0;
   int   errors = 0;
   int   n_data, n_dmrs, n_grp, n_sss, n_done;
   int   m_v, m_dcnt, m_mcnt;
`ifdef PBCH_DEMAP_SSS_EN
   localparam int SSS_PER_SSB = 127;
`else
   localparam int SSS_PER_SSB = 0;
`endif

   // driver + reference model: sym is the symbol the bench intends this beat to belong to
   task automatic send(input int sym, input int k, input bit sof, input bit start, input logic [1:0] v);
      exp_t e;
      bit   pbch;
      bus.fft_data  = {sym[15:0], k[15:0]};
      bus.fft_valid = 1'b1;
      bus.fft_sof   = sof;
      bus.ssb_start = start;
      bus.cell_v    = v;
      if (start) begin
         m_v = int'(v); m_dcnt = 0; m_mcnt = 0;
      end
      if (sym >= 1 && k < 240) begin
         pbch  = (sym == 1) || (sym == 3) || (sym == 2 && (k < 48 || k >= 192));
         e.val = bus.fft_data;
         if (pbch && (k % 4) == m_v) begin
            e.idx = m_mcnt; e.last = 1'b0; q_dmrs.push_back(e); m_mcnt++;
         end else if (pbch) begin
            e.idx = m_dcnt; e.last = ((m_dcnt % 3) == 2); q_data.push_back(e); m_dcnt++;
         end
`ifdef PBCH_DEMAP_SSS_EN
         if (sym == 2 && k >= 56 && k <= 182) begin
            e.idx = 0; e.last = 1'b0; q_sss.push_back(e);
         end
`endif
      end
      @(posedge clk_i); #1;
   endtask

   task automatic run_sym(input int sym, input int n, input bit start, input logic [1:0] v);
      for (int k = 0; k < n; k++) send(sym, k, k == 0, start && k == 0, v);
   endtask

   task automatic idle(input int n);
      bus.fft_valid = 1'b0; bus.fft_sof = 1'b0; bus.ssb_start = 1'b0;
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   task automatic clear_counts();
      n_data = 0; n_dmrs = 0; n_grp = 0; n_sss = 0; n_done = 0;
   endtask

   always @(negedge clk_i) begin : mon
      exp_t e;
      if (rst_ni) begin
         if (bus.data_valid) begin
            n_data++; if (bus.data_grp_last) n_grp++;
            checks++;
            if (q_data.size() == 0) begin
               errors++; $display("FAIL data_unexpected got %h idx %0d", bus.data_out, bus.data_idx);
            end else begin
               e = q_data.pop_front();
               if (bus.data_out !== e.val || bus.data_idx !== 9'(e.idx) || bus.data_grp_last !== e.last) begin
                  errors++;
                  $display("FAIL data_beat got %h/%0d/%b want %h/%0d/%b", bus.data_out, bus.data_idx,
                           bus.data_grp_last, e.val, e.idx, e.last);
               end
            end
         end
         if (bus.dmrs_valid) begin
            n_dmrs++; checks++;
            if (q_dmrs.size() == 0) begin
               errors++; $display("FAIL dmrs_unexpected got %h idx %0d", bus.dmrs_out, bus.dmrs_idx);
            end else begin
               e = q_dmrs.pop_front();
               if (bus.dmrs_out !== e.val || bus.dmrs_idx !== 8'(e.idx)) begin
                  errors++;
                  $display("FAIL dmrs_beat got %h/%0d want %h/%0d", bus.dmrs_out, bus.dmrs_idx, e.val, e.idx);
               end
            end
         end
         if (bus.sss_valid) begin
            n_sss++; checks++;
`ifdef PBCH_DEMAP_SSS_EN
            if (q_sss.size() == 0) begin
               errors++; $display("FAIL sss_unexpected got %h", bus.sss_out);
            end else begin
               e = q_sss.pop_front();
               if (bus.sss_out !== e.val) begin
                  errors++; $display("FAIL sss_beat got %h want %h", bus.sss_out, e.val);
               end
            end
`else
            errors++; $display("FAIL sss_disabled sss_valid high, want 0");
`endif
         end
         if (bus.data_valid || bus.dmrs_valid || bus.sss_valid) begin
            checks++;
            if (int'(bus.data_valid) + int'(bus.dmrs_valid) + int'(bus.sss_valid) > 1) begin
               errors++;
               $display("FAIL valid_exclusive got %b%b%b want one-hot", bus.data_valid, bus.dmrs_valid, bus.sss_valid);
            end
         end
         if (bus.ssb_done) n_done++;
      end
   end

   task automatic check_drained(input string name);
      checks++;
      if (q_data.size() != 0 || q_dmrs.size() != 0 || q_sss.size() != 0) begin
         errors++;
         $display("FAIL %s_drained got %0d/%0d/%0d pending want 0/0/0", name, q_data.size(), q_dmrs.size(), q_sss.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if ({bus.data_out, bus.data_valid, bus.data_idx, bus.data_grp_last, bus.dmrs_out, bus.dmrs_valid,
           bus.dmrs_idx, bus.sss_out, bus.sss_valid, bus.ssb_done, bus.err} !== '0) begin
         errors++; $display("FAIL reset_outputs got nonzero output, want all 0");
      end
      rst_ni = 1'b1;
      idle(2);
      checks++;
      if (bus.err !== 1'b0 || bus.data_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset got err %b dv %b want 0 0", bus.err, bus.data_valid);
      end
   endtask

   task automatic test_idle_ignore();
      clear_counts();
      for (int k = 0; k < 10; k++) send(0, k, k == 0, 1'b0, 2'd0);
      idle(2);
      checks++;
      if (bus.err !== 1'b0 || n_data != 0 || n_dmrs != 0) begin
         errors++; $display("FAIL idle_ignore got err %b data %0d dmrs %0d want 0 0 0", bus.err, n_data, n_dmrs);
      end
   endtask

   task automatic test_full_ssb_v0();
      clear_counts();
      run_sym(0, 240, 1'b1, 2'd0);
      run_sym(1, 240, 1'b0, 2'd0);
      run_sym(2, 240, 1'b0, 2'd0);
      run_sym(3, 240, 1'b0, 2'd0);
      bus.fft_valid = 1'b0;
      checks++;
      if (bus.data_valid !== 1'b1 || bus.data_idx !== 9'd431 || bus.ssb_done !== 1'b0) begin
         errors++; $display("FAIL last_data got dv %b idx %0d done %b want 1 431 0", bus.data_valid, bus.data_idx, bus.ssb_done);
      end
      idle(1);
      checks++;
      if (bus.ssb_done !== 1'b1) begin
         errors++; $display("FAIL ssb_done_pulse got %b want 1", bus.ssb_done);
      end
      idle(1);
      checks++;
      if (bus.ssb_done !== 1'b0) begin
         errors++; $display("FAIL ssb_done_single got %b want 0", bus.ssb_done);
      end
      idle(3);
      checks++;
      if (n_data != 432 || n_dmrs != 144 || n_done != 1 || n_sss != SSS_PER_SSB || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL full_ssb_counts got %0d/%0d/%0d/%0d err %b want 432/144/1/%0d 0",
                  n_data, n_dmrs, n_done, n_sss, bus.err, SSS_PER_SSB);
      end
      check_drained("full_ssb");
   endtask

   task automatic test_v3_sym2();
      run_sym(0, 240, 1'b1, 2'd3);
      run_sym(1, 240, 1'b0, 2'd3);
      idle(2);
      clear_counts();
      run_sym(2, 240, 1'b0, 2'd3);
      idle(2);
      checks++;
      if (n_dmrs != 24 || n_data != 72 || n_grp != 24 || n_sss != SSS_PER_SSB) begin
         errors++;
         $display("FAIL v3_sym2 got dmrs %0d data %0d grp %0d sss %0d want 24 72 24 %0d",
                  n_dmrs, n_data, n_grp, n_sss, SSS_PER_SSB);
      end
      check_drained("v3_sym2");
   endtask

   task automatic test_short_symbol();
      run_sym(0, 240, 1'b1, 2'd1);
      run_sym(1, 200, 1'b0, 2'd1);
      checks++;
      if (bus.err !== 1'b0) begin
         errors++; $display("FAIL short_pre_err got %b want 0", bus.err);
      end
      idle(2);
      clear_counts();
      run_sym(2, 240, 1'b0, 2'd1);
      idle(2);
      checks++;
      if (bus.err !== 1'b1 || n_data != 72 || n_dmrs != 24) begin
         errors++; $display("FAIL short_symbol got err %b data %0d dmrs %0d want 1 72 24", bus.err, n_data, n_dmrs);
      end
      send(0, 0, 1'b1, 1'b1, 2'd1);
      checks++;
      if (bus.err !== 1'b0) begin
         errors++; $display("FAIL short_err_clear got %b want 0", bus.err);
      end
      idle(2);
      check_drained("short");
   endtask

   task automatic test_long_symbol();
      idle(2);
      clear_counts();
      run_sym(0, 240, 1'b1, 2'd2);
      run_sym(1, 245, 1'b0, 2'd2);
      checks++;
      if (bus.err !== 1'b1) begin
         errors++; $display("FAIL long_err got %b want 1", bus.err);
      end
      run_sym(2, 240, 1'b0, 2'd2);
      run_sym(3, 240, 1'b0, 2'd2);
      idle(4);
      checks++;
      if (n_data != 432 || n_dmrs != 144 || n_done != 1 || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL long_counts got %0d/%0d/%0d err %b want 432/144/1 1", n_data, n_dmrs, n_done, bus.err);
      end
      check_drained("long");
   endtask

   task automatic test_restart_mid_sym2();
      idle(2);
      clear_counts();
      run_sym(0, 240, 1'b1, 2'd0);
      run_sym(1, 240, 1'b0, 2'd0);
      run_sym(2, 100, 1'b0, 2'd0);
      send(0, 0, 1'b1, 1'b1, 2'd0);
      checks++;
      if (bus.data_idx !== 9'd0 || bus.dmrs_idx !== 8'd0) begin
         errors++; $display("FAIL restart_idx got %0d/%0d want 0/0", bus.data_idx, bus.dmrs_idx);
      end
      clear_counts();
      for (int k = 1; k < 240; k++) send(0, k, 1'b0, 1'b0, 2'd0);
      checks++;
      if (n_done != 0) begin
         errors++; $display("FAIL restart_no_done got %0d want 0", n_done);
      end
      run_sym(1, 240, 1'b0, 2'd0);
      run_sym(2, 240, 1'b0, 2'd0);
      run_sym(3, 240, 1'b0, 2'd0);
      idle(4);
      checks++;
      if (n_data != 432 || n_dmrs != 144 || n_done != 1) begin
         errors++; $display("FAIL restart_counts got %0d/%0d/%0d want 432/144/1", n_data, n_dmrs, n_done);
      end
      check_drained("restart");
   endtask

   task automatic test_reset_mid_sym3();
      idle(2);
      clear_counts();
      run_sym(0, 240, 1'b1, 2'd0);
      run_sym(1, 240, 1'b0, 2'd0);
      run_sym(2, 240, 1'b0, 2'd0);
      run_sym(3, 100, 1'b0, 2'd0);
      bus.fft_valid = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({bus.data_out, bus.data_valid, bus.data_idx, bus.data_grp_last, bus.dmrs_out, bus.dmrs_valid,
           bus.dmrs_idx, bus.sss_out, bus.sss_valid, bus.ssb_done, bus.err} !== '0) begin
         errors++; $display("FAIL reset_mid_sym3 got nonzero output, want all 0");
      end
      q_data.delete(); q_dmrs.delete(); q_sss.delete();
      idle(2);
      rst_ni = 1'b1;
      idle(4);
      checks++;
      if (n_done != 0 || bus.err !== 1'b0 || bus.data_valid !== 1'b0) begin
         errors++; $display("FAIL reset_abort got done %0d err %b dv %b want 0 0 0", n_done, bus.err, bus.data_valid);
      end
   endtask

   initial begin
      bus.fft_data = '0; bus.fft_valid = 1'b0; bus.fft_sof = 1'b0; bus.ssb_start = 1'b0; bus.cell_v = '0;
      m_v = 0; m_dcnt = 0; m_mcnt = 0;
      clear_counts();
      test_reset();
      test_idle_ignore();
      test_full_ssb_v0();
      test_v3_sym2();
      test_short_symbol();
      test_long_symbol();
      test_restart_mid_sym2();
      test_reset_mid_sym3();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
